// File: rtl/riscv_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the fetch address and loads the
// IF/ID register. Decode can stall it, and execute can redirect it; a misaligned redirect halts it.
module riscv_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic [31:0] BR_TARGET,
    input  logic [31:0] INSTR,
    output logic [31:0] INSTR_ADDR,
    output logic [31:0] IF_ID_INSTR,
    output logic [31:0] IF_ID_PC,
    output logic        IF_ID_VALID,
    output logic        MISALIGN,
    output logic [31:0] FETCH_CNT
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic        r_if_valid;
    logic        r_misalign;
    logic [31:0] r_fetch_cnt;
    logic        w_target_aligned;

    assign w_target_aligned = (BR_TARGET[1:0] == 2'b00);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= BOOT;
            r_pc        <= RESET_PC;
            r_if_instr  <= NOP_WORD;
            r_if_pc     <= '0;
            r_if_valid  <= 1'b0;
            r_misalign  <= 1'b0;
            r_fetch_cnt <= '0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_if_instr <= NOP_WORD;
                    r_if_pc    <= '0;
                    r_if_valid <= 1'b0;
                    r_state    <= RUN;
                end
                RUN: begin
                    // FLUSH outranks STALL: a redirect drops any pending stall
                    if (FLUSH) begin
                        r_if_instr <= NOP_WORD;
                        r_if_pc    <= '0;
                        r_if_valid <= 1'b0;
                        if (w_target_aligned) begin
                            r_pc <= BR_TARGET;
                        end else begin
                            r_misalign <= 1'b1;
                            r_state    <= HALT;
                        end
                    end else if (!STALL) begin
                        r_if_instr  <= INSTR;
                        r_if_pc     <= r_pc;
                        r_if_valid  <= 1'b1;
                        r_pc        <= r_pc + 32'd4;
                        r_fetch_cnt <= r_fetch_cnt + 32'd1;
                    end
                end
                HALT: begin
                    r_if_instr <= NOP_WORD;
                    r_if_pc    <= '0;
                    r_if_valid <= 1'b0;
                    r_misalign <= 1'b1;
                end
                default: r_state <= HALT;
            endcase
        end
    end

    assign INSTR_ADDR  = r_pc;
    assign IF_ID_INSTR = r_if_instr;
    assign IF_ID_PC    = r_if_pc;
    assign IF_ID_VALID = r_if_valid;
    assign MISALIGN    = r_misalign;
    assign FETCH_CNT   = r_fetch_cnt;

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Bench for riscv_fetch_stage: directed scenarios followed by random steering,
// checked every edge against a behavioural model of the fetch stage.
module tb_riscv_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST, STALL, FLUSH;
    logic [31:0] BR_TARGET, INSTR;
    logic [31:0] INSTR_ADDR, IF_ID_INSTR, IF_ID_PC, FETCH_CNT;
    logic        IF_ID_VALID, MISALIGN;

    riscv_fetch_stage #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
        .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH), .BR_TARGET(BR_TARGET),
        .INSTR(INSTR), .INSTR_ADDR(INSTR_ADDR), .IF_ID_INSTR(IF_ID_INSTR),
        .IF_ID_PC(IF_ID_PC), .IF_ID_VALID(IF_ID_VALID), .MISALIGN(MISALIGN),
        .FETCH_CNT(FETCH_CNT)
    );

    always #5 CLK = ~CLK;

    // Code image at RESET_PC; any other address returns an address-derived word
    logic [31:0] image [22];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - RESET_PC;
        if (off[1:0] == 2'b00 && (off >> 2) < 32'd22) return image[off >> 2];
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    assign INSTR = instr_of(INSTR_ADDR);

    // Behavioural model: mode 0 = just out of reset, 1 = fetching, 2 = halted
    int          m_mode;
    logic [31:0] m_pc, m_ii, m_ip, m_cnt;
    logic        m_v, m_mis;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bubble();
        m_ii = NOP_WORD;
        m_ip = 32'd0;
        m_v  = 1'b0;
    endtask

    task automatic step(input logic rst, input logic stall, input logic flush,
                        input logic [31:0] tgt);
        RST = rst; STALL = stall; FLUSH = flush; BR_TARGET = tgt;
        if (rst) begin
            m_mode = 0; m_pc = RESET_PC; m_mis = 1'b0; m_cnt = 32'd0;
            bubble();
        end else if (m_mode == 0) begin
            m_mode = 1;
            bubble();
        end else if (m_mode == 1) begin
            if (flush) begin
                bubble();
                if (tgt % 4 == 0) m_pc = tgt;
                else begin
                    m_mis  = 1'b1;
                    m_mode = 2;
                end
            end else if (!stall) begin
                m_ii  = instr_of(m_pc);
                m_ip  = m_pc;
                m_v   = 1'b1;
                m_pc  = m_pc + 4;
                m_cnt = m_cnt + 1;
            end
        end else begin
            bubble();
        end
        @(posedge CLK);
        #1;
        check("INSTR_ADDR",  INSTR_ADDR,  m_pc);
        check("IF_ID_INSTR", IF_ID_INSTR, m_ii);
        check("IF_ID_PC",    IF_ID_PC,    m_ip);
        check("IF_ID_VALID", {31'd0, IF_ID_VALID}, {31'd0, m_v});
        check("MISALIGN",    {31'd0, MISALIGN},    {31'd0, m_mis});
        check("FETCH_CNT",   FETCH_CNT,   m_cnt);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        logic [31:0] tgt;
        logic        r, s, f;
        for (int i = 0; i < 22; i++) image[i] = $urandom;
        RST = 1'b1; STALL = 1'b0; FLUSH = 1'b0; BR_TARGET = 32'd0;

        // Reset and boot
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("reset_addr", INSTR_ADDR, 32'h0040_0000);
        step(1'b0, 1'b1, 1'b1, 32'h0000_1000);
        check("boot_valid", {31'd0, IF_ID_VALID}, 32'd0);
        check("boot_addr", INSTR_ADDR, 32'h0040_0000);
        run(1);
        check("first_pc", IF_ID_PC, 32'h0040_0000);
        check("first_next_addr", INSTR_ADDR, 32'h0040_0004);

        // Sequential run: 10 fetches in total
        run(9);
        check("seq_last_pc", IF_ID_PC, 32'h0040_0024);
        check("seq_last_instr", IF_ID_INSTR, image[9]);
        check("seq_count", FETCH_CNT, 32'd10);

        // Stall with PC at 0x00400008
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        run(2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'd0);
        check("stall_pc_held", INSTR_ADDR, 32'h0040_0008);
        run(1);
        check("stall_release_pc", IF_ID_PC, 32'h0040_0008);

        // Redirect with simultaneous stall
        step(1'b0, 1'b1, 1'b1, 32'h0040_0040);
        check("redir_nop", IF_ID_INSTR, 32'h0000_0013);
        check("redir_addr", INSTR_ADDR, 32'h0040_0040);
        run(1);
        check("redir_target_pc", IF_ID_PC, 32'h0040_0040);

        // Misaligned target halts until reset
        step(1'b0, 1'b0, 1'b1, 32'h0040_0042);
        for (int i = 0; i < 6; i++) step(1'b0, i[0], i[1], 32'h0040_0100);
        check("halt_misalign", {31'd0, MISALIGN}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("halt_reset_pc", INSTR_ADDR, 32'h0040_0000);
        step(1'b0, 1'b0, 1'b0, 32'd0);

        // PC wrap, then mid-run reset
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        run(1);
        check("wrap_pc", IF_ID_PC, 32'hFFFF_FFFC);
        check("wrap_addr", INSTR_ADDR, 32'h0000_0000);
        run(2);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("midrun_reset_cnt", FETCH_CNT, 32'd0);

        // Random steering
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(39) == 0);
            s = ($urandom_range(3) == 0);
            f = ($urandom_range(7) == 0);
            tgt = ($urandom_range(1) == 0) ? (RESET_PC + ($urandom_range(30) << 2)) : $urandom;
            if ($urandom_range(5) != 0) tgt[1:0] = 2'b00;
            step(r, s, f, tgt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
